prescale_multi: RTL and testbench

Parametrised multi-channel clock-enable prescaler for the 50 MHz domain. Each of NCH channels divides clk50m by a runtime-programmable divisor and emits a one-cycle enable pulse. Divisor changes take effect glitch-free at the channel's next wrap. A global sync restarts all channels phase-aligned. The block replaces fixed single-rate prescalers feeding DSM/DAC, UART and debounce logic.

---
 rtl/prescale_pkg.sv | 28 ++
 rtl/prescale_chan.sv | 86 ++++++++
 rtl/prescale_multi.sv | 88 ++++++++
 tb/tb_prescale_multi.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/prescale_pkg.sv
// prescale_pkg
// Shared definitions for the multi-channel clock-enable prescaler.
//   DIV_RST_DEF  : divisor loaded into every channel at reset (50 -> 1 MHz from 50 MHz)
//   NCH_MAX      : largest supported channel count
//   CHAN_W       : width of the per-channel counter/divisor registers
//   chan_state_t : per-channel state (down-counter, active divisor, shadow, pending flag)
//   wr_valid()   : divisor-write validity check (non-zero divisor, existing channel)
package prescale_pkg;

    localparam int DIV_RST_DEF = 50;
    localparam int NCH_MAX     = 16;
    localparam int CHAN_W      = 16;

    typedef struct packed {
        logic [CHAN_W-1:0] cnt;
        logic [CHAN_W-1:0] act;
        logic [CHAN_W-1:0] shd;
        logic              pend;
    } chan_state_t;

    // A write is accepted only for a non-zero divisor aimed at an existing channel.
    function automatic logic wr_valid(input logic [31:0] sel,
                                      input logic [31:0] nch,
                                      input logic        val_nz);
        return val_nz && (sel < nch) && (sel < 32'(NCH_MAX));
    endfunction

endpackage

// File: rtl/prescale_chan.sv
// prescale_chan
// One prescaler channel: down-counter, active divisor, shadow divisor,
// pending flag and registered one-cycle tick.
// Ports:
//   clk50m, rst_n : clock, asynchronous active-low reset
//   cnt_en        : count event for this channel this cycle
//   sync          : restart (applies pending shadow, reloads counter)
//   wr, wr_val    : validated write into the shadow divisor
//   wrap          : (only with PRESCALE_CASCADE_EN) this channel wraps this cycle
//   pend          : shadow holds a value not yet applied
//   tick          : one-cycle enable pulse, the cycle after a wrap
module prescale_chan
    import prescale_pkg::*;
#(
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic              clk50m,
    input  logic              rst_n,
    input  logic              cnt_en,
    input  logic              sync,
    input  logic              wr,
    input  logic [CHAN_W-1:0] wr_val,
`ifdef PRESCALE_CASCADE_EN
    output logic              wrap,
`endif
    output logic              pend,
    output logic              tick
);

    localparam logic [CHAN_W-1:0] RST_DIV = CHAN_W'(DIV_RST);
    localparam logic [CHAN_W-1:0] ONE     = {{(CHAN_W-1){1'b0}}, 1'b1};
    localparam logic [CHAN_W-1:0] ZERO    = {CHAN_W{1'b0}};
    localparam chan_state_t RST_ST = '{cnt: RST_DIV - ONE, act: RST_DIV, shd: RST_DIV, pend: 1'b0};

    chan_state_t       st_r;
    chan_state_t       st_nxt_s;
    logic              tick_r;
    logic              tick_nxt_s;
    logic              wrap_s;
    logic [CHAN_W-1:0] new_act_s;

    // Sync pre-empts a wrap, so a sync cycle never produces a tick.
    assign wrap_s    = cnt_en && !sync && (st_r.cnt == ZERO);
    assign new_act_s = st_r.pend ? st_r.shd : st_r.act;

    // Next-state: reload on sync or wrap, count down on other count events.
    always_comb begin
        st_nxt_s   = st_r;
        tick_nxt_s = 1'b0;
        if (sync || wrap_s) begin
            tick_nxt_s    = wrap_s;
            st_nxt_s.act  = new_act_s;
            st_nxt_s.cnt  = new_act_s - ONE;
            st_nxt_s.pend = 1'b0;
        end else if (cnt_en) begin
            st_nxt_s.cnt = st_r.cnt - ONE;
        end else begin
            st_nxt_s.cnt = st_r.cnt;
        end
        // A write lands after the reload decision, so it stays pending and wins over the clear.
        if (wr) begin
            st_nxt_s.shd  = wr_val;
            st_nxt_s.pend = 1'b1;
        end else begin
            st_nxt_s.shd  = st_nxt_s.shd;
        end
    end

    // Channel state and tick registers.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            st_r   <= RST_ST;
            tick_r <= 1'b0;
        end else begin
            st_r   <= st_nxt_s;
            tick_r <= tick_nxt_s;
        end
    end

`ifdef PRESCALE_CASCADE_EN
    assign wrap = wrap_s;
`endif
    assign pend = st_r.pend;
    assign tick = tick_r;

endmodule

// File: rtl/prescale_multi.sv
// prescale_multi
// Multi-channel clock-enable prescaler for the 50 MHz domain. Each channel
// divides clk50m by a runtime divisor and emits a one-cycle tick; divisor
// changes are applied at the channel's next wrap, sync restarts all channels.
// Optional feature: define PRESCALE_CASCADE_EN to chain channels so that
// channel k>0 only counts wraps of channel k-1.
// Ports:
//   rst_n, clk50m       : asynchronous active-low reset, clock
//   en                  : global run, low freezes all counters
//   sync                : synchronous phase-aligned restart
//   div_we/div_sel/div_val : divisor write strobe, channel, value
//   div_err             : one-cycle pulse after a rejected write
//   div_pending[NCH]    : shadow written, not yet applied
//   tick[NCH]           : one-cycle enable pulse per channel
module prescale_multi
    import prescale_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CNT_W   = 16,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic                                     rst_n,
    input  logic                                     clk50m,
    input  logic                                     en,
    input  logic                                     sync,
    input  logic                                     div_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] div_sel,
    input  logic [CNT_W-1:0]                         div_val,
    output logic                                     div_err,
    output logic [NCH-1:0]                           div_pending,
    output logic [NCH-1:0]                           tick
);

    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic           wr_ok_s;
    logic           div_err_r;
    logic [NCH-1:0] wr_s;
    logic [NCH-1:0] cnt_en_s;
`ifdef PRESCALE_CASCADE_EN
    logic [NCH-1:0] wrap_s;
`endif

    assign wr_ok_s = div_we && wr_valid(32'(div_sel), 32'(NCH), |div_val);

    // Rejected-write flag, visible the cycle after the write.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            div_err_r <= 1'b0;
        end else begin
            div_err_r <= div_we && !wr_ok_s;
        end
    end

    assign div_err = div_err_r;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        assign wr_s[k] = wr_ok_s && (div_sel == SEL_W'(k));

`ifdef PRESCALE_CASCADE_EN
        // Chained: a channel counts only the wraps of its predecessor.
        if (k == 0) begin : g_head
            assign cnt_en_s[k] = en;
        end else begin : g_link
            assign cnt_en_s[k] = en && wrap_s[k-1];
        end
`else
        assign cnt_en_s[k] = en;
`endif

        prescale_chan #(
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk50m  (clk50m),
            .rst_n   (rst_n),
            .cnt_en  (cnt_en_s[k]),
            .sync    (sync),
            .wr      (wr_s[k]),
            .wr_val  (CHAN_W'(div_val)),
`ifdef PRESCALE_CASCADE_EN
            .wrap    (wrap_s[k]),
`endif
            .pend    (div_pending[k]),
            .tick    (tick[k])
        );
    end

endmodule

// File: tb/tb_prescale_multi.sv
// tb_prescale_multi
// Scoreboard bench for prescale_multi: each stimulus cycle advances a
// behavioural model (events remaining until the next tick, per channel)
// and queues the expected registered outputs; a monitor pops one entry
// after every clock edge and compares tick, div_pending and div_err.
module tb_prescale_multi;

    localparam int NCH     = 3;
    localparam int CNT_W   = 16;
    localparam int DIV_RST = 50;
    localparam int SEL_W   = 2;
`ifdef PRESCALE_CASCADE_EN
    localparam bit CASCADE = 1'b1;
`else
    localparam bit CASCADE = 1'b0;
`endif

    logic             rst_n;
    logic             clk50m;
    logic             en;
    logic             sync;
    logic             div_we;
    logic [SEL_W-1:0] div_sel;
    logic [CNT_W-1:0] div_val;
    logic             div_err;
    logic [NCH-1:0]   div_pending;
    logic [NCH-1:0]   tick;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] pend;
        logic           err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: count events left until the next tick, divisors, pending.
    int   m_left[NCH];
    int   m_act[NCH];
    int   m_shd[NCH];
    bit   m_pend[NCH];

    prescale_multi #(
        .NCH     (NCH),
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_RST)
    ) dut (
        .rst_n       (rst_n),
        .clk50m      (clk50m),
        .en          (en),
        .sync        (sync),
        .div_we      (div_we),
        .div_sel     (div_sel),
        .div_val     (div_val),
        .div_err     (div_err),
        .div_pending (div_pending),
        .tick        (tick)
    );

    initial begin
        clk50m = 1'b0;
        forever #10 clk50m = ~clk50m;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, want);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_left[k] = DIV_RST;
            m_act[k]  = DIV_RST;
            m_shd[k]  = DIV_RST;
            m_pend[k] = 1'b0;
        end
    endtask

    // Advance the model by one clock edge with the given inputs and queue the outcome.
    task automatic model_step(input bit e, input bit s, input bit w, input int sl, input int v);
        exp_t x;
        bit   valid;
        bit   prev_wrap;
        bit   ev;
        x         = '0;
        prev_wrap = 1'b0;
        valid     = w && (v != 0) && (sl < NCH);
        for (int k = 0; k < NCH; k++) begin
            ev        = e && (!CASCADE || k == 0 || prev_wrap);
            prev_wrap = 1'b0;
            if (s) begin
                if (m_pend[k]) begin
                    m_act[k]  = m_shd[k];
                    m_pend[k] = 1'b0;
                end
                m_left[k] = m_act[k];
            end else if (ev) begin
                if (m_left[k] == 1) begin
                    x.tick[k] = 1'b1;
                    prev_wrap = 1'b1;
                    if (m_pend[k]) begin
                        m_act[k]  = m_shd[k];
                        m_pend[k] = 1'b0;
                    end
                    m_left[k] = m_act[k];
                end else begin
                    m_left[k] = m_left[k] - 1;
                end
            end
            if (valid && sl == k) begin
                m_shd[k]  = v;
                m_pend[k] = 1'b1;
            end
            x.pend[k] = m_pend[k];
        end
        x.err = w && !valid;
        exp_q.push_back(x);
    endtask

    // Drive one cycle of stimulus (called at a falling edge).
    task automatic step(input bit e, input bit s, input bit w, input int sl, input int v);
        en      = e;
        sync    = s;
        div_we  = w;
        div_sel = SEL_W'(sl);
        div_val = CNT_W'(v);
        model_step(e, s, w, sl, v);
        @(negedge clk50m);
    endtask

    task automatic idle_inputs();
        en      = 1'b0;
        sync    = 1'b0;
        div_we  = 1'b0;
        div_sel = '0;
        div_val = '0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_pending", 32'(div_pending), 32'd0);
        chk("rst_err", 32'(div_err), 32'd0);
    endtask

    // Let the monitor consume the last queued edge, then reset asynchronously.
    task automatic apply_reset();
        @(posedge clk50m);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk50m);
        check_reset_outputs();
        rst_n = 1'b1;
    endtask

    // Monitor: after every edge, compare DUT outputs against the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk50m);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("tick", 32'(tick), 32'(x.tick));
                chk("div_pending", 32'(div_pending), 32'(x.pend));
                chk("div_err", 32'(div_err), 32'(x.err));
            end
        end
    end

    initial begin
        int waited;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk50m);
        check_reset_outputs();
        rst_n = 1'b1;

        // Defaults, D=10 write to ch1 at cycle 20, rejected writes, en stall, write lost to reset.
        for (int c = 1; c <= 160; c++) begin
            step(!(c >= 120 && c <= 126), 1'b0,
                 (c == 20) || (c == 100) || (c == 110) || (c == 158),
                 (c == 110) ? 3 : ((c == 158) ? 2 : 1),
                 (c == 100) ? 0 : ((c == 158) ? 7 : 10));
        end
        apply_reset();

        // Pending D=5 on ch2, sync at cycle 33 with a concurrent write to ch0.
        for (int c = 1; c <= 100; c++) begin
            step(1'b1, c == 33, (c == 10) || (c == 33),
                 (c == 10) ? 2 : 0, (c == 10) ? 5 : 7);
        end

        // D0=5, D1=4, then an aligned restart.
        for (int c = 1; c <= 70; c++) begin
            step(1'b1, c == 3, (c == 1) || (c == 2),
                 (c == 1) ? 0 : 1, (c == 1) ? 5 : 4);
        end

        // Randomized traffic, including D=1, zero divisors and out-of-range selects.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 12)));
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk50m);
            #2;
            waited++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
